// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master transfer sequencer.
// Optional build macro used by spi_master_ctrl: SPI_LSB_FIRST_EN.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int unsigned SPI_DATA_W_DEF  = 8;
    localparam int unsigned SPI_CLK_DIV_DEF = 4;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: tick is high for one PClK cycle every CLK_DIV
// cycles; clear restarts the count so the next tick lands CLK_DIV cycles later.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic PClK,
    input  logic PRESETn,
    input  logic clear,
    output logic tick
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_tick_gen: CLK_DIV must be at least 1");
    end
    if ((64'd1 << CNT_W) < 64'(CLK_DIV)) begin : g_bad_cnt_w
        $error("spi_tick_gen: CNT_W too narrow for CLK_DIV");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Free-running 0..CLK_DIV-1 counter, restarted by clear
    always_ff @(posedge PClK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master transfer sequencer: one DATA_W word per start pulse,
// registered CS_n/SPI_CLK/MOSI, MISO sampled on each SPI_CLK rise.
// Build macro SPI_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W_DEF,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              PClK,
    input  logic              PRESETn,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SPI_CLK,
    output logic              CS_n,
    output logic              MOSI,
    input  logic              MISO
);

    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("spi_master_ctrl: DATA_W must be within 2..32");
    end

    localparam int unsigned     BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic            CLK_IDLE = SPI_MODE0[1];

    spi_state_e        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick;
    logic              tick_clr;

    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_next;

    assign tick_clr = (state == IDLE) && start;

`ifdef SPI_LSB_FIRST_EN
    assign first_bit  = tx_data[0];
    assign next_bit   = tx_sr[1];
    assign tx_shifted = tx_sr >> 1;
    assign rx_next    = {MISO, rx_sr[DATA_W-1:1]};
`else
    assign first_bit  = tx_data[DATA_W-1];
    assign next_bit   = tx_sr[DATA_W-2];
    assign tx_shifted = tx_sr << 1;
    assign rx_next    = {rx_sr[DATA_W-2:0], MISO};
`endif

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .PClK    (PClK),
        .PRESETn (PRESETn),
        .clear   (tick_clr),
        .tick    (tick)
    );

    // Transfer FSM with registered pin and status outputs
    always_ff @(posedge PClK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            SPI_CLK <= CLK_IDLE;
            CS_n    <= 1'b1;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        CS_n    <= 1'b0;
                        busy    <= 1'b1;
                        MOSI    <= first_bit;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        SPI_CLK <= ~CLK_IDLE;
                        rx_sr   <= rx_next;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (SPI_CLK != CLK_IDLE) begin
                            // Falling edge: advance MOSI unless the last bit just went out
                            SPI_CLK <= CLK_IDLE;
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                            end else begin
                                tx_sr   <= tx_shifted;
                                MOSI    <= next_bit;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            SPI_CLK <= ~CLK_IDLE;
                            rx_sr   <= rx_next;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        CS_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        MOSI    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
